// File: rtl/synth_pkg.sv
// synth_pkg: shared types and defaults for the polyphonic synthesis sequencer.
package synth_pkg;

    localparam int NUM_KEYS_DEFAULT = 128;
    localparam int KEY_W            = 7;

    typedef logic [KEY_W-1:0] key_t;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        SCAN,
        CAPTURE
    } sched_state_e;

    // Datapath control bundle presented alongside KEY each cycle.
    typedef struct packed {
        logic ld_phase;
        logic ld_count;
        logic ld_tone;
        logic tone_mux;
        logic counter_mux;
        logic phase_mux;
    } dp_ctrl_t;

endpackage

// File: rtl/note_event_table.sv
// note_event_table: per-key held/pend/act bitmaps, note event capture,
// the indexed read port for the key being scanned, and the sounding-voice count.
module note_event_table
    import synth_pkg::*;
#(
    parameter int NUM_KEYS = NUM_KEYS_DEFAULT
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       evt_valid,
    input  logic       evt_on,
    input  key_t       evt_key,
    input  key_t       rd_key,
    output logic       rd_held,
    output logic       rd_pend,
    output logic       rd_act,
    input  logic       set_act,
    input  logic       clr_act,
    input  logic       clr_pend,
    output logic [7:0] act_count
);

    logic [NUM_KEYS-1:0] held;
    logic [NUM_KEYS-1:0] pend;
    logic [NUM_KEYS-1:0] act;

    assign rd_held = held[rd_key];
    assign rd_pend = pend[rd_key];
    assign rd_act  = act[rd_key];

    // Scan updates first, then event capture, so an event on the key being
    // scanned overrides the scan's own pend clear and lands after the slot.
    always_ff @(posedge CLK or negedge RESET_N) begin
        // NOTE: the bitmaps are plain flops, not RAM, so they must be reset;
        // a stale act bit after reset would sound a voice nobody pressed.
        if (!RESET_N) begin
            held      <= '0;
            pend      <= '0;
            act       <= '0;
            act_count <= '0;
        end else begin
            if (set_act)  act[rd_key]  <= 1'b1;
            if (clr_act)  act[rd_key]  <= 1'b0;
            if (clr_pend) pend[rd_key] <= 1'b0;
            // NOTE: several non-blocking writes to the same bit in one block
            // resolve to the last one executed; the event block relies on it.
            if (evt_valid) begin
                if (evt_on) begin
                    held[evt_key] <= 1'b1;
                    pend[evt_key] <= 1'b1;
                end else begin
                    held[evt_key] <= 1'b0;
                end
            end
            if (set_act && !rd_act) begin
                act_count <= act_count + 8'd1;
            end else if (clr_act && rd_act) begin
                act_count <= act_count - 8'd1;
            end
        end
    end

endmodule

// File: rtl/note_scheduler.sv
// note_scheduler: per-sample key scan sequencer for the synthesis datapath.
// Clears the tone accumulator on each SAMPLE_TICK, walks every key once,
// then captures the summed sample. Optional NOTE_SCHED_VOICE_LIMIT_EN caps
// simultaneous voices at MAX_VOICES.
module note_scheduler
    import synth_pkg::*;
#(
    parameter int NUM_KEYS   = NUM_KEYS_DEFAULT,
    parameter int MAX_VOICES = 16
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        SAMPLE_TICK,
    input  logic        EVT_VALID,
    input  logic        EVT_ON,
    input  logic [6:0]  EVT_KEY,
    input  logic        NOTE_END,
    input  logic [31:0] TONE,
    output logic [6:0]  KEY,
    output logic        LD_PHASE,
    output logic        LD_COUNT,
    output logic        LD_TONE,
    output logic        TONE_MUX,
    output logic        COUNTER_MUX,
    output logic        PHASE_MUX,
    output logic        NOTE_ON,
    output logic [31:0] SAMPLE_OUT,
    output logic        SAMPLE_VALID,
    output logic [7:0]  ACTIVE_COUNT,
    output logic        OVERRUN
);

`ifdef NOTE_SCHED_VOICE_LIMIT_EN
    localparam bit LIMIT_EN = 1'b1;
`else
    localparam bit LIMIT_EN = 1'b0;
`endif
    // Without the limit the cap sits above any reachable count, so every start passes.
    localparam int   VOICE_CAP = LIMIT_EN ? MAX_VOICES : NUM_KEYS + 1;
    localparam key_t LAST_KEY  = key_t'(NUM_KEYS - 1);

    sched_state_e state_q, state_d;
    key_t         key_q, key_d;
    dp_ctrl_t     ctrl;
    logic         note_on;
    logic         set_act, clr_act, clr_pend;
    logic         capture;
    logic         rd_held, rd_pend, rd_act;
    logic [7:0]   act_count;
    logic         start_ok;
    logic [31:0]  sample_q;
    logic         valid_q;
    logic         overrun_q;

    note_event_table #(
        .NUM_KEYS (NUM_KEYS)
    ) u_table (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .evt_valid (EVT_VALID),
        .evt_on    (EVT_ON),
        .evt_key   (EVT_KEY),
        .rd_key    (key_q),
        .rd_held   (rd_held),
        .rd_pend   (rd_pend),
        .rd_act    (rd_act),
        .set_act   (set_act),
        .clr_act   (clr_act),
        .clr_pend  (clr_pend),
        .act_count (act_count)
    );

    // A retrigger of a sounding key never needs a free slot.
    assign start_ok = rd_act || (int'(act_count) < VOICE_CAP);

    // State, key pointer and output-stage registers.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= IDLE;
            key_q     <= '0;
            sample_q  <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            valid_q <= capture;
            if (capture) sample_q <= TONE;
            if (SAMPLE_TICK && state_q != IDLE) overrun_q <= 1'b1;
        end
    end

    // Next state and datapath strobes, decoded from the registered state and
    // KEY so they line up with the datapath's combinational reads of KEY.
    always_comb begin
        // NOTE: every output gets a default here; a path that skips an
        // assignment would otherwise infer a latch.
        state_d  = state_q;
        key_d    = key_q;
        ctrl     = '0;
        note_on  = 1'b0;
        set_act  = 1'b0;
        clr_act  = 1'b0;
        clr_pend = 1'b0;
        capture  = 1'b0;
        case (state_q)
            IDLE: begin
                if (SAMPLE_TICK) state_d = CLEAR;
            end
            CLEAR: begin
                ctrl.ld_tone = 1'b1;
                state_d      = SCAN;
                key_d        = '0;
            end
            SCAN: begin
                note_on = rd_held;
                if (rd_pend && start_ok) begin
                    // Start or retrigger: phase and counter restart from zero,
                    // so this voice adds nothing to the current sample.
                    ctrl.ld_phase = 1'b1;
                    ctrl.ld_count = 1'b1;
                    ctrl.ld_tone  = 1'b1;
                    ctrl.tone_mux = 1'b1;
                    set_act       = 1'b1;
                    clr_pend      = 1'b1;
                end else if (rd_act && !NOTE_END) begin
                    ctrl = '1;
                end else if (rd_act) begin
                    clr_act = 1'b1;
                end
                if (key_q == LAST_KEY) begin
                    state_d = CAPTURE;
                    key_d   = '0;
                end else begin
                    key_d = key_q + key_t'(1);
                end
            end
            CAPTURE: begin
                capture = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign KEY          = key_q;
    assign LD_PHASE     = ctrl.ld_phase;
    assign LD_COUNT     = ctrl.ld_count;
    assign LD_TONE      = ctrl.ld_tone;
    assign TONE_MUX     = ctrl.tone_mux;
    assign COUNTER_MUX  = ctrl.counter_mux;
    assign PHASE_MUX    = ctrl.phase_mux;
    assign NOTE_ON      = note_on;
    assign SAMPLE_OUT   = sample_q;
    assign SAMPLE_VALID = valid_q;
    assign ACTIVE_COUNT = act_count;
    assign OVERRUN      = overrun_q;

endmodule

// File: tb/tb_note_scheduler.sv
// tb_note_scheduler: directed bench for note_scheduler with a sample-level
// model of the key bitmaps and scan timing, plus a behavioural datapath.
module tb_note_scheduler;

    localparam int NK        = 128;
    localparam int MAXV      = 2;
    localparam int CAP_POS   = NK + 2;
    localparam int VALID_REL = NK + 3;
`ifdef NOTE_SCHED_VOICE_LIMIT_EN
    localparam int MODEL_CAP = MAXV;
`else
    localparam int MODEL_CAP = NK + 1;
`endif

    logic        CLK;
    logic        RESET_N;
    logic        SAMPLE_TICK;
    logic        EVT_VALID;
    logic        EVT_ON;
    logic [6:0]  EVT_KEY;
    logic        NOTE_END;
    logic [31:0] TONE;
    logic [6:0]  KEY;
    logic        LD_PHASE, LD_COUNT, LD_TONE;
    logic        TONE_MUX, COUNTER_MUX, PHASE_MUX;
    logic        NOTE_ON;
    logic [31:0] SAMPLE_OUT;
    logic        SAMPLE_VALID;
    logic [7:0]  ACTIVE_COUNT;
    logic        OVERRUN;

    logic [NK-1:0] end_req;
    logic [31:0]   tone_acc;

    note_scheduler #(
        .NUM_KEYS   (NK),
        .MAX_VOICES (MAXV)
    ) dut (
        .CLK          (CLK),
        .RESET_N      (RESET_N),
        .SAMPLE_TICK  (SAMPLE_TICK),
        .EVT_VALID    (EVT_VALID),
        .EVT_ON       (EVT_ON),
        .EVT_KEY      (EVT_KEY),
        .NOTE_END     (NOTE_END),
        .TONE         (TONE),
        .KEY          (KEY),
        .LD_PHASE     (LD_PHASE),
        .LD_COUNT     (LD_COUNT),
        .LD_TONE      (LD_TONE),
        .TONE_MUX     (TONE_MUX),
        .COUNTER_MUX  (COUNTER_MUX),
        .PHASE_MUX    (PHASE_MUX),
        .NOTE_ON      (NOTE_ON),
        .SAMPLE_OUT   (SAMPLE_OUT),
        .SAMPLE_VALID (SAMPLE_VALID),
        .ACTIVE_COUNT (ACTIVE_COUNT),
        .OVERRUN      (OVERRUN)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // A sounding voice adds a key-specific constant to the sample.
    function automatic logic [31:0] contrib(int k);
        return 32'(k * 1000 + 7);
    endfunction

    assign TONE     = tone_acc;
    assign NOTE_END = end_req[KEY];

    // Behavioural datapath: accumulator cleared or summed under the strobes.
    always @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) tone_acc <= '0;
        else if (LD_TONE) tone_acc <= TONE_MUX ? tone_acc + (PHASE_MUX ? contrib(int'(KEY)) : 32'd0) : 32'd0;
    end

    int n_vec;
    int n_bad;

    task automatic check(string name, logic [63:0] got, logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef enum int {A_IDLE, A_START, A_RUN, A_END} act_e;

    bit [NK-1:0]  mh, mp, ma;
    int           mcount;
    bit           mover;
    int           pos;          // 0 idle, 1 clear, 2..NK+1 key pos-2, NK+2 capture
    bit           mvalid;
    logic [31:0]  mout = '0;
    logic [31:0]  msum = '0;

    function automatic act_e m_action(int k);
        if (mp[k] && (ma[k] || mcount < MODEL_CAP)) return A_START;
        if (ma[k]) return end_req[k] ? A_END : A_RUN;
        return A_IDLE;
    endfunction

    // Advance the model by one cycle using the inputs seen at this edge.
    always @(posedge CLK or negedge RESET_N) begin
        int p;
        int k;
        if (!RESET_N) begin
            mh = '0; mp = '0; ma = '0;
            mcount = 0; mover = 0; pos = 0; mvalid = 0;
            mout = '0; msum = '0;
        end else begin
            p = pos;
            mvalid = (p == CAP_POS);
            if (p == CAP_POS) mout = msum;
            if (p == 1) msum = '0;
            if (p >= 2 && p < CAP_POS) begin
                k = p - 2;
                case (m_action(k))
                    A_START: begin
                        if (!ma[k]) mcount++;
                        ma[k] = 1'b1;
                        mp[k] = 1'b0;
                    end
                    A_RUN: msum += contrib(k);
                    A_END: begin
                        ma[k] = 1'b0;
                        mcount--;
                    end
                    default: ;
                endcase
            end
            if (EVT_VALID) begin
                if (EVT_ON) begin
                    mh[EVT_KEY] = 1'b1;
                    mp[EVT_KEY] = 1'b1;
                end else begin
                    mh[EVT_KEY] = 1'b0;
                end
            end
            if (SAMPLE_TICK && p != 0) mover = 1'b1;
            if (p == 0) pos = SAMPLE_TICK ? 1 : 0;
            else        pos = (p == CAP_POS) ? 0 : p + 1;
        end
    end

    // Compare every output against the model on each falling edge.
    always @(negedge CLK) begin
        bit         scan;
        int         k;
        act_e       a;
        bit         loads;
        logic [5:0] exp_ctrl;
        if (RESET_N) begin
            scan  = (pos >= 2 && pos < CAP_POS);
            k     = scan ? pos - 2 : 0;
            a     = scan ? m_action(k) : A_IDLE;
            loads = (a == A_START || a == A_RUN);
            exp_ctrl = {loads, loads, loads || pos == 1, loads, a == A_RUN, a == A_RUN};
            check("ctrl", {LD_PHASE, LD_COUNT, LD_TONE, TONE_MUX, COUNTER_MUX, PHASE_MUX}, exp_ctrl);
            check("note_on", NOTE_ON, scan && mh[k]);
            if (scan) check("key", KEY, k);
            check("sample_valid", SAMPLE_VALID, mvalid);
            check("sample_out", SAMPLE_OUT, mout);
            check("active_count", ACTIVE_COUNT, mcount);
            check("overrun", OVERRUN, mover);
        end
    end

    // ---------------- stimulus helpers ----------------
    int rel;   // cycle offset from the most recent accepted tick

    task automatic do_tick();
        SAMPLE_TICK = 1'b1;
        @(posedge CLK); #2;
        SAMPLE_TICK = 1'b0;
        rel = 1;
    endtask

    task automatic send_evt(bit on, int k);
        EVT_VALID = 1'b1;
        EVT_ON    = on;
        EVT_KEY   = k[6:0];
        @(posedge CLK); #2;
        EVT_VALID = 1'b0;
    endtask

    task automatic obs_at(int c);
        repeat (c - rel) @(posedge CLK);
        @(negedge CLK);
        rel = c;
    endtask

    task automatic finish_scan();
        obs_at(VALID_REL);
        check("valid_at_t131", SAMPLE_VALID, 1'b1);
    endtask

    task automatic check_reset(string name);
        check({name, "_key"}, KEY, 7'd0);
        check({name, "_ctrl"}, {LD_PHASE, LD_COUNT, LD_TONE, TONE_MUX, COUNTER_MUX, PHASE_MUX, NOTE_ON}, 7'd0);
        check({name, "_sample"}, {SAMPLE_VALID, SAMPLE_OUT}, 33'd0);
        check({name, "_status"}, {ACTIVE_COUNT, OVERRUN}, 9'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete by %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int nvalid;
        int vcyc;
        n_vec = 0; n_bad = 0; rel = 0;
        RESET_N = 1'b0;
        SAMPLE_TICK = 1'b0; EVT_VALID = 1'b0; EVT_ON = 1'b0; EVT_KEY = '0;
        end_req = '0;
        #1 check_reset("por");
        repeat (3) @(posedge CLK);
        #2 RESET_N = 1'b1;

        // Key 20 sounding, then reset in the middle of a scan.
        send_evt(1'b1, 20);
        do_tick(); finish_scan();
        do_tick(); finish_scan();
        check("key20_sample", SAMPLE_OUT, 32'd20007);
        do_tick();
        obs_at(42);
        check("midscan_key40", KEY, 7'd40);
        check("midscan_count", ACTIVE_COUNT, 8'd1);
        #1 RESET_N = 1'b0;
        #1 check_reset("midscan_reset");
        send_evt(1'b1, 5);                       // must be ignored
        repeat (2) @(posedge CLK);
        #2 RESET_N = 1'b1;
        do_tick();
        obs_at(2);
        check("fresh_key0", KEY, 7'd0);
        check("fresh_count", ACTIVE_COUNT, 8'd0);
        obs_at(7);
        check("evt_in_reset_ignored", LD_PHASE, 1'b0);
        obs_at(22);
        check("key20_cleared", LD_TONE, 1'b0);
        finish_scan();

        // Note-on key 60: start slot, then running slot.
        send_evt(1'b1, 60);
        do_tick();
        obs_at(62);
        check("k60_start_mux", {COUNTER_MUX, PHASE_MUX, TONE_MUX}, 3'b001);
        check("k60_start_ld", {LD_PHASE, LD_COUNT, LD_TONE}, 3'b111);
        finish_scan();
        check("k60_start_sample", SAMPLE_OUT, 32'd0);
        do_tick();
        obs_at(62);
        check("k60_run_mux", {COUNTER_MUX, PHASE_MUX, TONE_MUX}, 3'b111);
        check("k60_note_on", NOTE_ON, 1'b1);
        check("k60_count", ACTIVE_COUNT, 8'd1);
        finish_scan();
        check("k60_run_sample", SAMPLE_OUT, 32'd60007);

        // Note-off key 60 with release finished.
        send_evt(1'b0, 60);
        end_req[60] = 1'b1;
        do_tick();
        obs_at(62);
        check("k60_end_ld", {LD_PHASE, LD_COUNT, LD_TONE, NOTE_ON}, 4'b0000);
        finish_scan();
        check("k60_end_count", ACTIVE_COUNT, 8'd0);
        end_req[60] = 1'b0;
        do_tick();
        obs_at(62);
        check("k60_off_note_on", {NOTE_ON, LD_TONE}, 2'b00);
        finish_scan();

        // Overrun: keys 3 and 100 sounding, second tick 50 cycles after the first.
        send_evt(1'b1, 3);
        send_evt(1'b1, 100);
        do_tick(); finish_scan();
        do_tick();
        nvalid = 0; vcyc = 0;
        for (int c = 1; c <= 200; c++) begin
            @(negedge CLK);
            if (c == 50) SAMPLE_TICK = 1'b1;
            if (c == 51) SAMPLE_TICK = 1'b0;
            if (SAMPLE_VALID) begin
                nvalid++;
                vcyc = c;
            end
        end
        check("overrun_valid_count", nvalid, 1);
        check("overrun_valid_cycle", vcyc, 131);
        check("overrun_flag", OVERRUN, 1'b1);
        check("overrun_sample", SAMPLE_OUT, 32'd103014);

        // Note-on key 10 in the very cycle key 10 is scanned.
        do_tick();
        obs_at(12);
        check("k10_same_cycle_idle", {LD_TONE, NOTE_ON}, 2'b00);
        EVT_VALID = 1'b1; EVT_ON = 1'b1; EVT_KEY = 7'd10;
        @(negedge CLK);
        EVT_VALID = 1'b0;
        rel = 13;
        finish_scan();
        do_tick();
        obs_at(12);
        check("k10_next_start", {COUNTER_MUX, LD_PHASE}, 2'b01);
        finish_scan();

        // Release every voice.
        end_req = '1;
        do_tick(); finish_scan();
        check("all_released", ACTIVE_COUNT, 8'd0);
        end_req = '0;

        // Voice cap: keys 1, 2, 3 requested together.
        send_evt(1'b1, 1);
        send_evt(1'b1, 2);
        send_evt(1'b1, 3);
        do_tick();
        obs_at(5);
`ifdef NOTE_SCHED_VOICE_LIMIT_EN
        check("cap_k3_held_off", LD_PHASE, 1'b0);
        finish_scan();
        check("cap_count", ACTIVE_COUNT, 8'd2);
`else
        check("nocap_k3_start", LD_PHASE, 1'b1);
        finish_scan();
        check("nocap_count", ACTIVE_COUNT, 8'd3);
`endif
        end_req[1] = 1'b1;
        do_tick();
        obs_at(3);
        check("k1_ends", LD_TONE, 1'b0);
        obs_at(5);
`ifdef NOTE_SCHED_VOICE_LIMIT_EN
        check("cap_k3_starts", {COUNTER_MUX, LD_PHASE}, 2'b01);
`else
        check("nocap_k3_runs", {COUNTER_MUX, LD_PHASE}, 2'b11);
`endif
        finish_scan();
        check("cap_count_after", ACTIVE_COUNT, 8'd2);
        end_req[1] = 1'b0;

        repeat (3) @(posedge CLK);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/note_scheduler.md
# note_scheduler

Sample-rate sequencer for the polyphonic synthesis datapath. On each sample tick it clears the tone accumulator, then walks all keys one per clock. For each key it drives the datapath's key select, mux selects, load strobes and NOTE_ON, and it tracks which notes are sounding. It then presents the summed 32-bit sample to the audio output stage. Note-on/off events from the NIOS II Avalon side are captured asynchronously to the scan and applied at the key's next scan slot.

## Interface
- NUM_KEYS, 128, number of keys scanned per sample (power of two)
- MAX_VOICES, 16, simultaneous voice cap (used only with NOTE_SCHED_VOICE_LIMIT_EN)

- CLK  in  1  system clock
- RESET_N  in  1  reset, asynchronous assert, active-low
- SAMPLE_TICK  in  1  one-cycle strobe at audio sample rate
- EVT_VALID  in  1  note event strobe
- EVT_ON  in  1  1 = note-on, 0 = note-off
- EVT_KEY  in  7  key of event
- NOTE_END  in  1  datapath: current key's release finished
- TONE  in  32  datapath accumulator
- KEY  out  7  key select to datapath
- LD_PHASE, LD_COUNT, LD_TONE  out  1 each  datapath load strobes
- TONE_MUX, COUNTER_MUX, PHASE_MUX  out  1 each  datapath mux selects
- NOTE_ON  out  1  key-held flag for current KEY
- SAMPLE_OUT  out  32  captured sample
- SAMPLE_VALID  out  1  one-cycle strobe, SAMPLE_OUT new
- ACTIVE_COUNT  out  8  voices currently sounding
- OVERRUN  out  1  sticky: tick arrived while not IDLE

## Operation
- Per-key bitmaps: held (key down), pend (start requested), act (voice sounding).
- Event apply, every cycle:
  - Note-on sets held[k] and pend[k].
  - Note-off clears held[k].
  - An event on the key being scanned in the same cycle takes effect after that scan; the scan uses the pre-event bits.
- FSM states:
  - IDLE: all strobes 0. SAMPLE_TICK → CLEAR.
  - CLEAR: LD_TONE=1, TONE_MUX=0 → SCAN with KEY=0.
  - SCAN: one key per cycle, KEY=k; NOTE_ON=held[k]. After k=NUM_KEYS-1 → CAPTURE.
  - CAPTURE: SAMPLE_OUT<=TONE, SAMPLE_VALID=1 next cycle → IDLE.
- SCAN action for key k:
  - pend[k] (start or retrigger; this case takes priority): COUNTER_MUX=0, PHASE_MUX=0, LD_PHASE=LD_COUNT=LD_TONE=1, TONE_MUX=1. Result: the voice contributes 0 this sample. Set act[k], clear pend[k].
  - act[k] & ~NOTE_END: all muxes=1, LD_PHASE=LD_COUNT=LD_TONE=1.
  - act[k] & NOTE_END: no loads; clear act[k].
  - otherwise: all strobes 0, muxes 0.
- ACTIVE_COUNT = popcount(act), maintained incrementally. A retrigger of an active key does not increment it.
- SAMPLE_TICK outside IDLE is dropped and sets OVERRUN. Only reset clears OVERRUN.

## Timing
- Tick seen in cycle t: CLEAR at t+1, key k at t+2+k, CAPTURE at t+NUM_KEYS+2, SAMPLE_VALID at t+NUM_KEYS+3 (131 for 128 keys).
- Datapath reads are combinational on KEY; strobes are registered-out so they align with KEY in the same cycle.
- Reset (any time, including mid-scan):
  - Outputs: all 0.
  - State: IDLE.
  - Bitmaps: all clear.
  - ACTIVE_COUNT: 0.
  - OVERRUN: 0.
- Events arriving during reset are ignored.

## Configuration
- NOTE_SCHED_VOICE_LIMIT_EN defined: a pend[k] start is taken only if ACTIVE_COUNT < MAX_VOICES, or if act[k] is set (retrigger). Otherwise pend[k] stays set and key k is treated as idle. Voices that end earlier in the scan free slots for later keys in the same scan.
- Undefined: no cap; every pending start is taken at its slot.

## Structure
- Package synth_pkg: NUM_KEYS default, key_t (7-bit), sched_state_e (IDLE, CLEAR, SCAN, CAPTURE).
- One sub-module, note_event_table: holds the held/pend/act bitmaps, the event-apply logic and the indexed read port for KEY. The scheduler FSM drives its set/clear of act and pend.

## Test plan
- Reset mid-scan (KEY=40): RESET_N low → all outputs 0. After release, next tick starts a fresh scan from KEY=0 with ACTIVE_COUNT=0.
- Note-on key 60, then tick: at t+62, COUNTER_MUX=PHASE_MUX=0 and all three loads asserted. On the next tick, muxes=1 and NOTE_ON=1. ACTIVE_COUNT=1.
- Note-off key 60, model NOTE_END=1 at KEY=60: no loads in that slot; ACTIVE_COUNT returns to 0. NOTE_ON=0 for key 60 on every scan after the note-off.
- Tick followed by a second tick 50 cycles later: OVERRUN=1; exactly one SAMPLE_VALID, at t+131. SAMPLE_OUT equals the model TONE value.
- Note-on key 10 issued in the cycle KEY=10 is scanned: that scan shows key 10 idle; the following scan starts it.
- With NOTE_SCHED_VOICE_LIMIT_EN and MAX_VOICES=2: note-on keys 1, 2, 3 → only keys 1 and 2 start. Once key 1 hits NOTE_END, key 3 starts in the same scan (slot 3 > slot 1).
